// File: rtl/demux_hs_n.sv
// demux_hs_n: registered 1-to-N demux with per-channel valid/ack and timeout.
// Optional DEMUX_HOLD_EN keeps the last delivered word on each channel slice.
module demux_hs_n #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int TIMEOUT  = 16,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SELW-1:0]           in_sel,
  input  logic                      mode,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ack,
  output logic [SELW-1:0]           cur_sel,
  output logic                      err
);

  // A zero TIMEOUT still gets a 1-bit counter that simply never moves.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [TW-1:0] T_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
  localparam logic [SELW-1:0] P_LAST = SELW'(CHANNELS - 1);
  localparam logic [SELW:0] CH_N = (SELW + 1)'(CHANNELS);

`ifdef DEMUX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [SELW-1:0] ptr_q;
  logic [TW-1:0]   cnt_q;
  logic [SELW-1:0] tgt;
  logic            tgt_ok;
  logic            accept;
  logic            ack_hit;
  logic            to_hit;

  assign in_ready = (state_q == IDLE);

  // Target decode, handshake events and next state.
  always_comb begin
    tgt     = mode ? ptr_q : in_sel;
    tgt_ok  = ({1'b0, tgt} < CH_N);
    accept  = in_valid && (state_q == IDLE);
    ack_hit = (state_q == BUSY) && (|(out_ack & out_valid));
    to_hit  = TO_EN && (state_q == BUSY) &&
              !ack_hit && (cnt_q == T_LAST);
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): if (accept && tgt_ok) state_d = BUSY;
      (state_q == BUSY): if (ack_hit || to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Channel data, valid, pointer, timeout counter and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      cur_sel   <= '0;
      err       <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      err <= (accept && !tgt_ok) || to_hit;
      if (accept && mode)
        ptr_q <= (ptr_q == P_LAST) ? '0 : ptr_q + 1'b1;
      if (accept && tgt_ok) begin
        out_valid <= CHANNELS'(1) << tgt;
        cur_sel   <= tgt;
        cnt_q     <= '0;
        for (int c = 0; c < CHANNELS; c++)
          if (tgt == SELW'(c))
            out_data[c*WIDTH +: WIDTH] <= in_data;
      end else if (ack_hit || to_hit) begin
        out_valid <= '0;
        if (!HOLD) out_data <= '0;
      end else if (state_q == BUSY && cnt_q != T_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_hs_n.sv
// tb_demux_hs_n: randomized model-based bench for demux_hs_n.
// Covers a 4-channel/TIMEOUT=16 and a 3-channel/TIMEOUT=0 instance.
module tb_demux_hs_n;

`ifdef DEMUX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        mode = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ack = '0;
  logic [1:0]  cur_sel;
  logic        err;

  logic        t3_in_valid = 1'b0;
  logic        t3_in_ready;
  logic [3:0]  t3_in_data = '0;
  logic [1:0]  t3_in_sel = '0;
  logic        t3_mode = 1'b0;
  logic [11:0] t3_out_data;
  logic [2:0]  t3_out_valid;
  logic [2:0]  t3_out_ack = '0;
  logic [1:0]  t3_cur_sel;
  logic        t3_err;

  int checks = 0;
  int failures = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  demux_hs_n #(.WIDTH(4), .CHANNELS(4), .TIMEOUT(TO)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .mode(mode),
    .out_data(out_data), .out_valid(out_valid),
    .out_ack(out_ack), .cur_sel(cur_sel), .err(err)
  );

  demux_hs_n #(.WIDTH(4), .CHANNELS(3), .TIMEOUT(0)) u3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(t3_in_valid), .in_ready(t3_in_ready),
    .in_data(t3_in_data), .in_sel(t3_in_sel), .mode(t3_mode),
    .out_data(t3_out_data), .out_valid(t3_out_valid),
    .out_ack(t3_out_ack), .cur_sel(t3_cur_sel), .err(t3_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer on the 4-channel instance. ackat = BUSY edge index that
  // carries the ack (beyond TO means never). noise: 0 none, 1 all other
  // channels acked, 2 random acks on other channels.
  task automatic xfer(input logic [3:0] d, input logic m,
                      input logic [1:0] s, input int ackat,
                      input int noise);
    int ch;
    logic [3:0] oh;
    logic [3:0] other;
    logic [3:0] exp_slice;
    bit done;
    bit exp_err;
    ch = m ? m_ptr : int'(s);
    oh = 4'b0001 << ch;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL pre_ready got=%b exp=1", in_ready);
    end
    in_valid = 1'b1; in_data = d; mode = m; in_sel = s; out_ack = '0;
    step();
    in_valid = 1'b0;
    if (m) m_ptr = (m_ptr + 1) % 4;
    checks++;
    if (out_valid !== oh) begin
      failures++;
      $display("FAIL acc_valid got=%b exp=%b", out_valid, oh);
    end
    checks++;
    if (out_data[ch*4 +: 4] !== d) begin
      failures++;
      $display("FAIL acc_data got=%h exp=%h", out_data[ch*4 +: 4], d);
    end
    checks++;
    if (cur_sel !== 2'(ch)) begin
      failures++;
      $display("FAIL acc_sel got=%0d exp=%0d", cur_sel, ch);
    end
    checks++;
    if (in_ready !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL acc_rdy_err got=%b%b exp=00", in_ready, err);
    end
    done = 1'b0;
    for (int k = 1; k <= TO + 8 && !done; k++) begin
      case (noise)
        1: other = ~oh;
        2: other = 4'($urandom) & ~oh;
        default: other = '0;
      endcase
      out_ack = other | ((k == ackat) ? oh : 4'b0000);
      mode = 1'($urandom);
      in_sel = 2'($urandom);
      step();
      if (k == ackat || k == TO) begin
        done = 1'b1;
        exp_err = (k != ackat);
        exp_slice = HOLD ? d : 4'h0;
        out_ack = '0;
        checks++;
        if (out_valid !== 4'b0 || in_ready !== 1'b1) begin
          failures++;
          $display("FAIL end_vr got=%b/%b exp=0000/1 k=%0d",
                   out_valid, in_ready, k);
        end
        checks++;
        if (err !== exp_err) begin
          failures++;
          $display("FAIL end_err got=%b exp=%b k=%0d", err, exp_err, k);
        end
        checks++;
        if (out_data[ch*4 +: 4] !== exp_slice || cur_sel !== 2'(ch)) begin
          failures++;
          $display("FAIL end_data got=%h/%0d exp=%h/%0d",
                   out_data[ch*4 +: 4], cur_sel, exp_slice, ch);
        end
        if (!HOLD) begin
          checks++;
          if (out_data !== 16'h0) begin
            failures++;
            $display("FAIL end_zero got=%h exp=0000", out_data);
          end
        end
      end else begin
        checks++;
        if (out_valid !== oh || in_ready !== 1'b0 || err !== 1'b0) begin
          failures++;
          $display("FAIL busy got=%b/%b/%b exp=%b/0/0 k=%0d",
                   out_valid, in_ready, err, oh, k);
        end
      end
    end
    out_ack = '0;
    step();
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b1 || out_valid !== 4'b0) begin
      failures++;
      $display("FAIL post got=%b/%b/%b exp=0/1/0000",
               err, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0 || out_data !== 16'h0 ||
        cur_sel !== 2'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset4 got=%b %b %h %0d %b exp=1 0000 0000 0 0",
               in_ready, out_valid, out_data, cur_sel, err);
    end
    checks++;
    if (t3_in_ready !== 1'b1 || t3_out_valid !== 3'b0 ||
        t3_out_data !== 12'h0 || t3_cur_sel !== 2'b0 ||
        t3_err !== 1'b0) begin
      failures++;
      $display("FAIL reset3 got=%b %b %h %0d %b exp=1 000 000 0 0",
               t3_in_ready, t3_out_valid, t3_out_data, t3_cur_sel, t3_err);
    end
  endtask

  task automatic test_direct();
    xfer(4'hA, 1'b0, 2'd2, 1, 0);
  endtask

  task automatic test_scan();
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) xfer(4'hC, 1'b0, 2'd3, 1, 0);
      xfer(4'(i), 1'b1, 2'd0, 1, 0);
    end
  endtask

  task automatic test_timeout();
    xfer(4'h5, 1'b0, 2'd1, 99, 0);
    xfer(4'h6, 1'b0, 2'd1, TO, 0);
    xfer(4'h7, 1'b0, 2'd1, TO - 1, 0);
  endtask

  task automatic test_wrong_ack();
    xfer(4'h3, 1'b0, 2'd0, 4, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      xfer(4'($urandom), 1'($urandom), 2'($urandom),
           $urandom_range(1, 20), 2);
  endtask

  task automatic test_range();
    logic [3:0] d;
    logic [3:0] exp_slice;
    logic [2:0] oh;
    int p3;
    d = 4'($urandom_range(1, 15));
    exp_slice = HOLD ? d : 4'h0;
    t3_in_valid = 1'b1; t3_in_data = d; t3_in_sel = 2'd2; t3_mode = 1'b0;
    step();
    t3_in_valid = 1'b0;
    checks++;
    if (t3_out_valid !== 3'b100 || t3_out_data[11:8] !== d ||
        t3_cur_sel !== 2'd2) begin
      failures++;
      $display("FAIL r_acc got=%b/%h/%0d exp=100/%h/2",
               t3_out_valid, t3_out_data[11:8], t3_cur_sel, d);
    end
    repeat (20) begin
      step();
      checks++;
      if (t3_out_valid !== 3'b100 || t3_err !== 1'b0) begin
        failures++;
        $display("FAIL r_noto got=%b/%b exp=100/0", t3_out_valid, t3_err);
      end
    end
    t3_out_ack = 3'b100;
    step();
    t3_out_ack = '0;
    checks++;
    if (t3_out_valid !== 3'b0 || t3_err !== 1'b0 ||
        t3_out_data[11:8] !== exp_slice) begin
      failures++;
      $display("FAIL r_ack got=%b/%b/%h exp=000/0/%h",
               t3_out_valid, t3_err, t3_out_data[11:8], exp_slice);
    end
    t3_in_valid = 1'b1; t3_in_data = 4'hF; t3_in_sel = 2'd3;
    step();
    t3_in_valid = 1'b0;
    checks++;
    if (t3_err !== 1'b1 || t3_out_valid !== 3'b0 || t3_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL r_oor got=%b/%b/%b exp=1/000/1",
               t3_err, t3_out_valid, t3_in_ready);
    end
    checks++;
    if (t3_cur_sel !== 2'd2 || t3_out_data[11:8] !== exp_slice) begin
      failures++;
      $display("FAIL r_keep got=%0d/%h exp=2/%h",
               t3_cur_sel, t3_out_data[11:8], exp_slice);
    end
    step();
    checks++;
    if (t3_err !== 1'b0 || t3_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL r_pulse got=%b/%b exp=0/1", t3_err, t3_in_ready);
    end
    p3 = 0;
    for (int i = 0; i < 4; i++) begin
      oh = 3'b001 << p3;
      t3_in_valid = 1'b1; t3_mode = 1'b1; t3_in_data = 4'(i + 1);
      step();
      t3_in_valid = 1'b0; t3_mode = 1'b0;
      checks++;
      if (t3_out_valid !== oh || t3_out_data[p3*4 +: 4] !== 4'(i + 1)) begin
        failures++;
        $display("FAIL r_scan got=%b exp=%b i=%0d", t3_out_valid, oh, i);
      end
      t3_out_ack = oh;
      step();
      t3_out_ack = '0;
      p3 = (p3 + 1) % 3;
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (m_ptr != 1 && guard < 8) begin
      xfer(4'h2, 1'b1, 2'd0, 1, 0);
      guard++;
    end
    in_valid = 1'b1; in_data = 4'h9; mode = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    m_ptr = 0;
    checks++;
    if (out_valid !== 4'b0 || out_data !== 16'h0 || cur_sel !== 2'b0 ||
        err !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst got=%b %h %0d %b %b exp=0000 0000 0 0 1",
               out_valid, out_data, cur_sel, err, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b1 || out_valid !== 4'b0) begin
      failures++;
      $display("FAIL mid_rel got=%b/%b/%b exp=0/1/0000",
               err, in_ready, out_valid);
    end
    xfer(4'hB, 1'b1, 2'd3, 1, 0);
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_timeout();
    test_wrong_ack();
    test_range();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/demux_hs_n.md
# demux_hs_n

Parametrised, registered 1-to-N demultiplexer with a valid/ack handshake on every output channel. It is the successor to the fixed combinational 1-to-4 demux. Each accepted input word is steered to one channel, either addressed directly or chosen by an internal round-robin scan pointer. The word is held on that channel until the consumer acknowledges it or a timeout expires. It sits between a single producer (control FSM or input decoder) and several consumers (display digits, actuator drivers).

## Interface
Parameters:
- WIDTH, 4: data word width, ≥1.
- CHANNELS, 4: output channel count, ≥2; SELW = $clog2(CHANNELS).
- TIMEOUT, 16: maximum BUSY cycles waiting for ack; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  WIDTH  word to route.
- in_sel  in  SELW  target channel in direct mode.
- mode  in  1  0 = direct (in_sel), 1 = scan (internal pointer).
- out_data  out  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- out_valid  out  CHANNELS  one-hot or zero; channel holds a word.
- out_ack  in  CHANNELS  consumer c takes its word.
- cur_sel  out  SELW  channel of the current or last transfer.
- err  out  1  one-cycle pulse: timeout or out-of-range in_sel.

## Operation
- Reset values:
  - State is IDLE and in_ready = 1.
  - out_valid, out_data, cur_sel and err are all 0.
  - The scan pointer and the timeout counter are 0.
- The FSM has two states: IDLE and BUSY.
- IDLE accepts a word on a clock edge where in_valid & in_ready.
  - The target channel is in_sel when mode = 0, or the scan pointer when mode = 1.
  - mode and in_sel are sampled only at accept; changes while BUSY have no effect.
- Scan pointer:
  - Advances on every accept made with mode = 1, including transfers that later time out.
  - Wraps from CHANNELS-1 to 0.
  - It is not changed by direct-mode accepts.
- Out-of-range in_sel (≥ CHANNELS, possible only when CHANNELS is not a power of 2):
  - The word is accepted and dropped.
  - err pulses and the state stays IDLE.
  - cur_sel is not updated.
- Valid accept:
  - The word is latched into channel ch.
  - out_valid[ch] = 1 and cur_sel = ch.
  - The state moves to BUSY and the timeout counter clears.
- BUSY:
  - On an edge with out_ack[ch] = 1: out_valid clears and the state returns to IDLE.
  - Acks on non-selected channels are ignored.
  - If TIMEOUT > 0 and TIMEOUT BUSY edges pass without ack: out_valid clears, err pulses and the state returns to IDLE.
  - Ack and timeout on the same edge: ack wins and err stays 0.
- The timeout counter is SELW-independent and $clog2(TIMEOUT+1) bits wide. It saturates and never wraps.
- Reset asserted mid-transfer aborts immediately with all reset values. No err is raised.

## Timing
- Accept at edge E0. out_valid[ch] and out_data are valid after E0, i.e. latency is 1 cycle.
- An ack sampled at E1 returns to IDLE after E1, so in_ready = 1 in the next cycle. The earliest next accept is E2.
- Maximum throughput is one word per 2 cycles.
- in_ready is decoded from the state register only and has no combinational path from in_valid or out_ack.
- With no ack, timeout fires at edge E_TIMEOUT. err is high for exactly the one cycle after that edge.
- err for out-of-range in_sel is high for the one cycle after the accepting edge.

## Configuration
- DEMUX_HOLD_EN defined:
  - Each channel keeps the last word delivered to it on out_data after out_valid drops.
  - The word changes only when that channel is next selected.
- DEMUX_HOLD_EN undefined:
  - A channel's out_data slice reads 0 whenever its out_valid is 0.
  - The slice is cleared on the edge that clears out_valid.
- Handshake, latency and err behaviour are identical in both builds.

## Test plan
- Direct route: WIDTH=4, CHANNELS=4, mode=0, in_sel=2, in_data=0xA.
  - Expect out_valid=0100, slice 2 = 0xA and cur_sel=2 one cycle after accept.
  - Ack on channel 2 next cycle: in_ready returns high the following cycle.
- Scan rotation: mode=1, five transfers of 0x1..0x5, each acked immediately.
  - Expect channels 0,1,2,3,0 in order.
  - Interleave one mode=0 transfer with in_sel=3 and check the pointer does not advance.
- Timeout: TIMEOUT=16, accept to channel 1 and never ack.
  - Expect out_valid[1] high for 16 cycles, then cleared, with err high for exactly 1 cycle and in_ready=1.
  - Repeat with ack on the 16th edge: no err.
- Wrong-channel ack: BUSY on channel 0 with out_ack=1110 asserted.
  - Expect BUSY to persist; out_ack=0001 then releases it.
- Range and hold: CHANNELS=3, in_sel=3 gives the err pulse, no out_valid and state stays IDLE.
  - With DEMUX_HOLD_EN, check a delivered slice retains its value after ack.
  - Without it, check the slice reads 0 after ack.
- Reset mid-transfer: assert rst_n=0 asynchronously while BUSY.
  - Expect out_valid, out_data, cur_sel and err at 0 and in_ready=1 immediately, with no err after release.
